// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter that shares one instruction memory among N_CORES cores.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP; all outputs are registered.
module imem_arbiter #(
    parameter int N_CORES = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic [N_CORES-1:0]    req,
    input  logic [N_CORES*AW-1:0] addr_flat,
    output logic [N_CORES-1:0]    gnt,
    output logic [N_CORES-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  mem_read,
    output logic [AW-1:0]         mem_addr,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_win;
    logic [3:0]           r_cnt;
    logic                 r_drop;
    logic [N_CORES-1:0]   r_gnt;
    logic [N_CORES-1:0]   r_rvalid;
    logic [DW-1:0]        r_rdata;
    logic                 r_mem_read;
    logic [AW-1:0]        r_mem_addr;
    logic [PW-1:0]        w_win;
    logic [N_CORES-1:0]   w_win_oh;
    logic                 w_drop;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = N_CORES - 1; k >= 0; k--)
            if (req[(int'(r_ptr) + k) % N_CORES]) w_win = PW'((int'(r_ptr) + k) % N_CORES);
    end

    assign w_win_oh = N_CORES'(1) << w_win;
    // A request withdrawn at any point of the access suppresses its response.
    assign w_drop   = r_drop | ~req[r_win];

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rvalid <= '0;
                    if (enable && |req) begin
                        r_state    <= ACCESS;
                        r_gnt      <= w_win_oh;
                        r_mem_read <= 1'b1;
                        r_mem_addr <= addr_flat[int'(w_win)*AW +: AW];
                        r_cnt      <= 4'(MEM_LAT - 1);
                        r_ptr      <= PW'((int'(w_win) + 1) % N_CORES);
                        r_win      <= w_win;
                        r_drop     <= 1'b0;
                    end
                end
                ACCESS: begin
                    r_drop <= w_drop;
                    if (r_cnt == 4'd0) begin
                        r_state    <= RESP;
                        r_rdata    <= mem_rdata;
                        r_mem_read <= 1'b0;
                        r_gnt      <= '0;
                        r_rvalid   <= w_drop ? '0 : r_gnt;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_rvalid <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign mem_read = r_mem_read;
    assign mem_addr = r_mem_addr;
    assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances;
// responses are predicted into per-instance queues and popped when rvalid pulses.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        en1 = 1'b0, en3 = 1'b0;
    logic [3:0]  req1 = '0, req3 = '0;
    logic [63:0] addr1 = '0, addr3 = '0;
    logic [3:0]  gnt1, gnt3, rv1, rv3;
    logic [15:0] rd1, rd3, ma1, ma3, mrd1, mrd3;
    logic        mr1, mr3, busy1, busy3;
    logic [19:0] q1[$];
    logic [19:0] q3[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    function automatic logic [3:0] oh(input int c);
        return 4'b0001 << c;
    endfunction

    assign mrd1 = mem(ma1);
    assign mrd3 = mem(ma3);

    imem_arbiter #(.N_CORES(4), .AW(16), .DW(16), .MEM_LAT(1)) u1 (
        .clk(clk), .RESET(RESET), .enable(en1), .req(req1), .addr_flat(addr1),
        .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .mem_read(mr1), .mem_addr(ma1),
        .mem_rdata(mrd1), .busy(busy1));

    imem_arbiter #(.N_CORES(4), .AW(16), .DW(16), .MEM_LAT(3)) u3 (
        .clk(clk), .RESET(RESET), .enable(en3), .req(req3), .addr_flat(addr3),
        .gnt(gnt3), .rvalid(rv3), .rdata(rd3), .mem_read(mr3), .mem_addr(ma3),
        .mem_rdata(mrd3), .busy(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rvalid pulse must match the oldest predicted response.
    always @(negedge clk) begin
        if (RESET) begin
            chk("gnt1_onehot", 32'($onehot0(gnt1)), 32'd1);
            chk("rv1_onehot", 32'($onehot0(rv1)), 32'd1);
            chk("gnt3_onehot", 32'($onehot0(gnt3)), 32'd1);
            chk("rv3_onehot", 32'($onehot0(rv3)), 32'd1);
            if (rv1 != 4'd0) chk("sb1_resp", 32'({rv1, rd1}), 32'(q1.size() != 0 ? q1.pop_front() : 20'd0));
            if (rv3 != 4'd0) chk("sb3_resp", 32'({rv3, rd3}), 32'(q3.size() != 0 ? q3.pop_front() : 20'd0));
        end
    end

    initial begin
        #2;
        chk("rst_gnt", 32'({gnt1, gnt3}), 32'd0);
        chk("rst_rvalid", 32'({rv1, rv3}), 32'd0);
        chk("rst_memrd_busy", 32'({mr1, mr3, busy1, busy3}), 32'd0);
        chk("rst_memaddr", 32'({ma1, ma3}), 32'd0);
        chk("rst_rdata", 32'({rd1, rd3}), 32'd0);
        tick();
        tick();
        RESET = 1'b1;

        // single request, MEM_LAT=1
        addr1[15:0] = 16'h0010;
        req1 = 4'b0001;
        en1 = 1'b1;
        q1.push_back({4'b0001, 16'hA5A5});
        tick();
        chk("t1_gnt", 32'(gnt1), 32'h1);
        chk("t1_memrd", 32'(mr1), 32'd1);
        chk("t1_memaddr", 32'(ma1), 32'h0010);
        chk("t1_busy", 32'(busy1), 32'd1);
        tick();
        chk("t1_gnt_off", 32'(gnt1), 32'd0);
        chk("t1_memrd_off", 32'(mr1), 32'd0);
        chk("t1_rvalid", 32'(rv1), 32'h1);
        chk("t1_rdata", 32'(rd1), 32'hA5A5);
        chk("t1_busy_resp", 32'(busy1), 32'd1);
        req1 = 4'b0000;
        tick();
        chk("t1_idle", 32'({busy1, rv1}), 32'd0);
        chk("t1_rdata_hold", 32'(rd1), 32'hA5A5);
        chk("t1_memaddr_hold", 32'(ma1), 32'h0010);

        // all four requesting from reset: order 0,1,2,3,0 spaced 3 cycles
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) addr1[i*16 +: 16] = 16'h1000 + 16'(i * 16'h111);
        req1 = 4'b1111;
        for (int g = 0; g < 5; g++) q1.push_back({oh(g % 4), mem(addr1[(g % 4)*16 +: 16])});
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_gnt", 32'(gnt1), 32'(oh(g % 4)));
            chk("t2_memaddr", 32'(ma1), 32'(addr1[(g % 4)*16 +: 16]));
            tick();
            chk("t2_resp_gnt", 32'(gnt1), 32'd0);
            chk("t2_rvalid", 32'(rv1), 32'(oh(g % 4)));
            tick();
            chk("t2_idle_gnt", 32'({gnt1, busy1}), 32'd0);
            if (g == 4) req1 = 4'b0000;
        end

        // core 1 withdraws mid-access: no rvalid, pointer still moves on to core 2
        req1 = 4'b0110;
        tick();
        chk("t3_gnt", 32'(gnt1), 32'h2);
        req1 = 4'b0100;
        tick();
        chk("t3_suppressed", 32'(rv1), 32'd0);
        chk("t3_busy", 32'(busy1), 32'd1);
        q1.push_back({4'b0100, mem(addr1[2*16 +: 16])});
        tick();
        tick();
        chk("t3_next_gnt", 32'(gnt1), 32'h4);
        tick();
        chk("t3_rvalid", 32'(rv1), 32'h4);
        req1 = 4'b0000;
        tick();

        // enable low blocks grants; raising it grants on the next edge (ptr now at 3)
        en1 = 1'b0;
        req1 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_gnt", 32'({gnt1, mr1, busy1}), 32'd0);
        end
        en1 = 1'b1;
        tick();
        chk("t4_gnt", 32'(gnt1), 32'h8);

        // asynchronous reset in mid-access, then restart from core 0
        #1;
        RESET = 1'b0;
        #1;
        chk("t5_async", 32'({gnt1, mr1, busy1, rv1}), 32'd0);
        tick();
        RESET = 1'b1;
        q1.push_back({4'b0001, mem(addr1[15:0])});
        tick();
        chk("t5_gnt0", 32'(gnt1), 32'h1);
        tick();
        chk("t5_rvalid", 32'(rv1), 32'h1);
        req1 = 4'b0000;
        tick();

        // MEM_LAT=3 instance: read held 3 cycles, address latched at grant
        addr3[2*16 +: 16] = 16'h2468;
        req3 = 4'b0100;
        en3 = 1'b1;
        q3.push_back({4'b0100, mem(16'h2468)});
        tick();
        chk("t6_gnt", 32'(gnt3), 32'h4);
        chk("t6_memaddr", 32'(ma3), 32'h2468);
        chk("t6_rd_busy", 32'({mr3, busy3}), 32'h3);
        addr3[2*16 +: 16] = 16'hFFFF;
        tick();
        chk("t6_rd2", 32'({mr3, busy3}), 32'h3);
        chk("t6_addr_latched", 32'(ma3), 32'h2468);
        tick();
        chk("t6_rd3", 32'({mr3, busy3, rv3}), 32'h30);
        tick();
        chk("t6_rd_off", 32'(mr3), 32'd0);
        chk("t6_rvalid", 32'(rv3), 32'h4);
        chk("t6_rdata", 32'(rd3), 32'(mem(16'h2468)));
        chk("t6_busy_resp", 32'(busy3), 32'd1);
        req3 = 4'b0000;
        tick();
        chk("t6_idle", 32'({busy3, rv3, gnt3}), 32'd0);

        // enable dropped during access: access still completes
        addr3[15:0] = 16'h0ABC;
        req3 = 4'b0001;
        q3.push_back({4'b0001, mem(16'h0ABC)});
        tick();
        chk("t7_gnt", 32'(gnt3), 32'h1);
        en3 = 1'b0;
        tick();
        tick();
        tick();
        chk("t7_rvalid", 32'(rv3), 32'h1);
        req3 = 4'b0000;
        tick();
        tick();

        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb3_drained", 32'(q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, the number of requesting cores (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter AW, default 16, the instruction address width.
REQ-003 The block SHALL have parameter DW, default 16, the instruction width.
REQ-004 The block SHALL have parameter MEM_LAT, default 1, the number of cycles mem_read is held per access (legal range 1-15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: when high, the block may grant; when low, no new grant.
REQ-008 The block SHALL have port req, input, N_CORES bits: per-core instruction fetch request, level-sensitive.
REQ-009 The block SHALL have port addr_flat, input, N_CORES*AW bits: core i address at bits [i*AW +: AW].
REQ-010 The block SHALL have port gnt, output, N_CORES bits: one-hot grant, high for the whole access.
REQ-011 The block SHALL have port rvalid, output, N_CORES bits: one-cycle pulse marking rdata valid for core i.
REQ-012 The block SHALL have port rdata, output, DW bits: captured instruction, broadcast to all cores.
REQ-013 The block SHALL have port mem_read, output, 1 bit: read strobe to the instruction memory.
REQ-014 The block SHALL have port mem_addr, output, AW bits: address to the instruction memory.
REQ-015 The block SHALL have port mem_rdata, input, DW bits: combinational instruction memory output.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-018 IDLE: if enable=1 and req!=0, select winner w by round-robin starting at index ptr; next state ACCESS; gnt[w], the latched address and mem_read become visible in the following cycle.
REQ-019 Round-robin: search order ptr, ptr+1, ... mod N_CORES; at each grant, ptr SHALL be loaded with (w+1) mod N_CORES.
REQ-020 Address SHALL be latched from addr_flat slice w at grant; mem_addr = latched address for all of ACCESS; later addr_flat changes SHALL be ignored.
REQ-021 ACCESS: mem_read=1 for exactly MEM_LAT cycles, counted by a 4-bit counter; in the last ACCESS cycle rdata <= mem_rdata; next state RESP.
REQ-022 RESP: rvalid[w]=1 for one cycle, gnt deasserts; next state IDLE.
REQ-023 A new grant SHALL NOT occur in the RESP cycle; minimum spacing between grants is MEM_LAT+2 cycles.
REQ-024 Latency: req rising in cycle t (IDLE, enable=1, uncontested) SHALL give gnt from t+1, and rvalid at t+MEM_LAT+1.
REQ-025 If req[w] drops during ACCESS, the access SHALL complete, but rvalid[w] SHALL be suppressed; ptr is still advanced.
REQ-026 If enable falls during ACCESS, the access in flight SHALL complete normally.
REQ-027 rdata SHALL hold its value until the next capture.
REQ-028 gnt SHALL be one-hot or zero at all times; rvalid SHALL be one-hot or zero at all times.
REQ-029 Outside ACCESS, mem_read SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-030 On RESET=0 (asynchronous), the FSM SHALL go to IDLE with ptr=0, gnt=0, rvalid=0, mem_read=0, busy=0, mem_addr=0, rdata=0 and the latency counter=0.
REQ-031 A reset mid-access SHALL abort the access with no rvalid; after reset release, arbitration SHALL restart from index 0.

Verification
REQ-032 Single request, MEM_LAT=1: req=0001, addr0=0x0010, mem_rdata=0xA5A5 -> gnt=0001 for 1 cycle, mem_addr=0x0010, mem_read=1, then rvalid=0001 with rdata=0xA5A5.
REQ-033 All four requesting continuously, from reset -> grant order 0,1,2,3,0; each grant spaced 3 cycles; no gnt overlap.
REQ-034 MEM_LAT=3, req=0100 -> mem_read high exactly 3 cycles, rvalid[2] at t+4, busy high t+1..t+4.
REQ-035 req[1] dropped in mid-ACCESS -> access completes, rvalid stays 0000, next grant goes to core 2 if it requests.
REQ-036 RESET pulled low during ACCESS -> gnt, mem_read and busy go to 0 immediately (asynchronously); with req=1111 held, first post-reset grant goes to core 0.
REQ-037 enable=0 with req=1111 -> gnt stays 0 and mem_read stays 0; enable raised -> grant in the next cycle.
